// File: rtl/mdu_iterative_if.sv
// Execute-stage handshake bundle between the pipeline and the iterative multiply/divide unit.
// The pipeline drives the request side; the unit returns busy, done and result.
interface mdu_iterative_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rda;
  logic [WIDTH-1:0] rdb;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, rda, rdb, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, op, rda, rdb, flush,
    output busy, done, result
  );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, fixed WIDTH+1 cycle latency.
// The operands are held as magnitudes while iterating, and the sign is applied once in FIN.
module mdu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           nrst,
  mdu_iterative_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [2:0]         r_op;
  logic               r_neg;
  logic [WIDTH-1:0]   r_divisor;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_busy;
  logic [WIDTH-1:0]   r_result;

  logic               w_sgn_a;
  logic               w_sgn_b;
  logic               w_neg_a;
  logic               w_neg_b;
  logic               w_res_neg;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_trial;
  logic [2*WIDTH-1:0] w_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_fin;
  logic               w_done;

  always_comb begin
    w_sgn_a = 1'b0;
    w_sgn_b = 1'b0;
    case (bus.op)
      3'd0, 3'd1, 3'd4, 3'd6: begin
        w_sgn_a = 1'b1;
        w_sgn_b = 1'b1;
      end
      3'd2:    w_sgn_a = 1'b1;
      default: ;
    endcase
  end

  assign w_neg_a = w_sgn_a & bus.rda[WIDTH-1];
  assign w_neg_b = w_sgn_b & bus.rdb[WIDTH-1];
  assign w_mag_a = w_neg_a ? -bus.rda : bus.rda;
  assign w_mag_b = w_neg_b ? -bus.rdb : bus.rdb;

  // A zero divisor yields an all-ones quotient that must not be negated.
  always_comb begin
    if (!bus.op[2])
      w_res_neg = w_neg_a ^ w_neg_b;
    else if (bus.op[1])
      w_res_neg = w_neg_a;
    else
      w_res_neg = (w_neg_a ^ w_neg_b) & (|bus.rdb);
  end

  assign w_add   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_divisor} : '0);
  assign w_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_divisor};

  always_comb begin
    if (!r_op[2])
      w_step = {w_add, r_acc[WIDTH-1:1]};
    else if (!w_trial[WIDTH])
      w_step = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    else
      w_step = {r_acc[2*WIDTH-2:WIDTH-1], r_acc[WIDTH-2:0], 1'b0};
  end

  assign w_prod = r_neg ? -r_acc : r_acc;

  always_comb begin
    w_fin = '0;
    if (!r_op[2])
      w_fin = (r_op[1:0] == 2'd0) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];
    else if (r_op[1])
      w_fin = r_neg ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    else
      w_fin = r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_neg     <= 1'b0;
      r_divisor <= '0;
      r_acc     <= '0;
      r_busy    <= 1'b0;
      r_result  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            r_op      <= bus.op;
            r_neg     <= w_res_neg;
            r_divisor <= bus.op[2] ? w_mag_b : w_mag_a;
            r_acc     <= {{WIDTH{1'b0}}, (bus.op[2] ? w_mag_a : w_mag_b)};
            r_cnt     <= CW'(WIDTH - 1);
            r_busy    <= 1'b1;
            r_state   <= CALC;
          end
        end
        CALC: begin
          if (bus.flush) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_acc <= w_step;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == '0) begin
              r_busy  <= 1'b0;
              r_state <= FIN;
            end
          end
        end
        FIN: begin
          if (!bus.flush)
            r_result <= w_fin;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // done and the presented result are gated so a flush in the FIN cycle can still cancel them.
  assign w_done     = (r_state == FIN) && !bus.flush;
  assign bus.busy   = r_busy;
  assign bus.done   = w_done;
  assign bus.result = w_done ? w_fin : r_result;
endmodule

// File: tb/tb_mdu_iterative.sv
// Bench for mdu_iterative: directed RV32M cases plus random traffic checked against a cycle-count model.
module tb_mdu_iterative;
  localparam int WIDTH = 32;

  logic clk;
  logic nrst;
  int   checks;
  int   errors;

  mdu_iterative_if #(.WIDTH(WIDTH)) bus ();

  mdu_iterative #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    logic [31:0] r;
    int sia, sib, q;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    sia = signed'(a);
    sib = signed'(b);
    r   = '0;
    case (op)
      3'd0: begin p = sa * sb; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin q = sia / sib; r = q; end
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
        else begin q = sia % sib; r = q; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: cycles since acceptance; k=1..WIDTH busy, k=WIDTH+1 is the done cycle.
  bit          m_active;
  int          m_k;
  logic [31:0] m_exp;
  logic [31:0] m_result;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_active = 1'b0;
      m_k      = 0;
      m_exp    = '0;
      m_result = '0;
    end else if (!m_active) begin
      if (bus.start && !bus.flush) begin
        m_active = 1'b1;
        m_k      = 1;
        m_exp    = ref_mdu(bus.op, bus.rda, bus.rdb);
      end
    end else if (m_k == WIDTH + 1) begin
      if (!bus.flush) m_result = m_exp;
      m_active = 1'b0;
    end else if (bus.flush) begin
      m_active = 1'b0;
    end else begin
      m_k++;
    end
  end

  always @(negedge clk) begin
    logic e_busy, e_done;
    if (nrst) begin
      e_busy = m_active && (m_k <= WIDTH);
      e_done = m_active && (m_k == WIDTH + 1) && !bus.flush;
      chk("mdl_busy", 32'(bus.busy), 32'(e_busy));
      chk("mdl_done", 32'(bus.done), 32'(e_done));
      chk("mdl_result", bus.result, e_done ? m_exp : m_result);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_chk(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    bus.start = 1'b1;
    bus.op    = op;
    bus.rda   = a;
    bus.rdb   = b;
    tick();
    bus.start = 1'b0;
    bus.rda   = ~a;
    bus.rdb   = b + 32'd5;
    bus.op    = op + 3'd3;
    chk({name, "_busy_c1"}, 32'(bus.busy), 32'd1);
    repeat (31) tick();
    chk({name, "_busy_c32"}, 32'(bus.busy), 32'd1);
    chk({name, "_done_c32"}, 32'(bus.done), 32'd0);
    tick();
    chk({name, "_done_c33"}, 32'(bus.done), 32'd1);
    chk({name, "_busy_c33"}, 32'(bus.busy), 32'd0);
    chk({name, "_res_c33"}, bus.result, exp);
    tick();
    chk({name, "_done_c34"}, 32'(bus.done), 32'd0);
    chk({name, "_hold_c34"}, bus.result, exp);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return $urandom_range(0, 20);
      6:       return -($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int guard;
    checks    = 0;
    errors    = 0;
    nrst      = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = '0;
    bus.rda   = '0;
    bus.rdb   = '0;

    chk("pin_mul",    ref_mdu(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    chk("pin_mulh",   ref_mdu(3'd1, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
    chk("pin_mulhsu", ref_mdu(3'd2, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFF);
    chk("pin_div",    ref_mdu(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("pin_rem",    ref_mdu(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("pin_remu0",  ref_mdu(3'd7, 32'h1234, 32'd0), 32'h0000_1234);

    repeat (2) tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    tick();

    run_chk("mul",     3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_chk("mulh",    3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_chk("mulhu",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_chk("mulhsu",  3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
    run_chk("div",     3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_chk("rem",     3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_chk("divu",    3'd5, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF);
    run_chk("div0",    3'd4, 32'h1234, 32'd0, 32'hFFFF_FFFF);
    run_chk("divu0",   3'd5, 32'h1234, 32'd0, 32'hFFFF_FFFF);
    run_chk("remu0",   3'd7, 32'h1234, 32'd0, 32'h0000_1234);
    run_chk("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_chk("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

    // Start while busy is ignored.
    bus.start = 1'b1; bus.op = 3'd0; bus.rda = 32'd5; bus.rdb = 32'd6;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.start = 1'b1; bus.op = 3'd5; bus.rda = 32'd77; bus.rdb = 32'd3;
    tick();
    bus.start = 1'b0;
    repeat (21) tick();
    tick();
    chk("ign_done_c33", 32'(bus.done), 32'd1);
    chk("ign_res_c33", bus.result, 32'd30);
    tick();

    // Flush at cycle 20, new start at cycle 21 completes at cycle 54.
    bus.start = 1'b1; bus.op = 3'd5; bus.rda = 32'd100; bus.rdb = 32'd7;
    tick();
    bus.start = 1'b0;
    repeat (19) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_busy_c21", 32'(bus.busy), 32'd0);
    chk("flush_done_c21", 32'(bus.done), 32'd0);
    chk("flush_res_c21", bus.result, 32'd30);
    bus.start = 1'b1; bus.op = 3'd7; bus.rda = 32'd100; bus.rdb = 32'd7;
    tick();
    bus.start = 1'b0;
    chk("restart_busy", 32'(bus.busy), 32'd1);
    repeat (31) tick();
    chk("restart_done_c53", 32'(bus.done), 32'd0);
    tick();
    chk("restart_done_c54", 32'(bus.done), 32'd1);
    chk("restart_res_c54", bus.result, 32'd2);
    tick();

    // Start together with flush in IDLE is dropped.
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'd0; bus.rda = 32'd9; bus.rdb = 32'd9;
    tick();
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("idle_flush_busy", 32'(bus.busy), 32'd0);
    tick();

    // Asynchronous reset in the middle of a divide.
    bus.start = 1'b1; bus.op = 3'd4; bus.rda = 32'hFFFF_FF9C; bus.rdb = 32'd7;
    tick();
    bus.start = 1'b0;
    repeat (14) tick();
    #2 nrst = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_result", bus.result, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    tick();
    run_chk("mul_after_rst", 3'd0, 32'd3, 32'd4, 32'd12);

    for (int n = 0; n < 200; n++) begin
      repeat ($urandom_range(0, 3)) begin
        bus.start = ($urandom_range(0, 5) == 0);
        bus.flush = bus.start;
        tick();
      end
      bus.flush = 1'b0;
      bus.start = 1'b1;
      bus.op    = 3'($urandom_range(0, 7));
      bus.rda   = pick();
      bus.rdb   = pick();
      tick();
      bus.start = 1'b0;
      guard = 0;
      while (m_active && guard < 60) begin
        bus.flush = ($urandom_range(0, 59) == 0);
        bus.start = ($urandom_range(0, 7) == 0);
        bus.op    = 3'($urandom_range(0, 7));
        bus.rda   = $urandom;
        bus.rdb   = $urandom;
        tick();
        guard++;
      end
      bus.flush = 1'b0;
      bus.start = 1'b0;
      if (guard >= 60) chk("rand_timeout", 32'(m_active), 32'd0);
    end

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Iterative RV32M multiply/divide unit that sits beside the single-cycle ALU on the same execute-stage operand bus (rda, rdb after the operand mux).
- Takes the M-extension ops the single-cycle ALU does not implement.
- Computes over a fixed number of cycles with a start/busy/done handshake; the hazard/stall logic holds the pipeline while busy is high.
- Its result is muxed onto the writeback path in place of the ALU result.

Parameters:
- WIDTH, 32, operand and result width. The algorithm requires an even value of 4 or more; 32 for RV32.

Ports:
- clk  input  1  system clock, rising edge
- nrst  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU (RISC-V funct3 encoding)
- rda  input  WIDTH  operand A, rs1: multiplicand / dividend
- rdb  input  WIDTH  operand B, rs2: multiplier / divisor
- flush  input  1  abort the in-flight operation (branch mispredict / trap)
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse; result is valid in this cycle
- result  output  WIDTH  final value; held until the next accepted start

Behaviour:
- Reset (async, nrst=0): state=IDLE; busy=0, done=0, result=0; all internal registers cleared. Reset mid-operation abandons the operation silently; no done is produced.
- States: IDLE -> CALC -> FIN -> IDLE.
- IDLE:
  - If start=1, latch op, rda, rdb.
  - Convert operands to magnitudes and record the result-sign flags per op (signed/unsigned per RISC-V).
  - Load the iteration counter with WIDTH-1 and go to CALC.
  - busy rises in the next cycle.
- CALC: one iteration per cycle.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring divide, one quotient bit per cycle.
  - The counter decrements each cycle; when counter==0, go to FIN. CALC always lasts exactly WIDTH cycles.
- FIN:
  - Apply sign correction.
  - Select low word (MUL), high word (MULH/MULHSU/MULHU), quotient (DIV/DIVU) or remainder (REM/REMU).
  - Register result and pulse done=1 for this cycle only; busy=0 in this cycle; return to IDLE.
- Latency: start accepted at cycle 0 -> done at cycle WIDTH+1 (cycle 33 for WIDTH=32), for every op and every operand value. Fixed latency is intentional.
- start while busy or in FIN: ignored; no queueing.
- flush=1 in CALC or FIN: go to IDLE next cycle; done stays 0; result keeps its previous value. flush takes priority over start in the same cycle.
- flush=1 in IDLE: no effect, and any start in that cycle is dropped.
- Divide by zero (rdb=0):
  - DIV/DIVU -> all ones (0xFFFFFFFF).
  - REM/REMU -> rda.
  - No trap; latency unchanged.
- Signed overflow (DIV/REM, rda=0x80000000, rdb=0xFFFFFFFF): DIV -> 0x80000000, REM -> 0. Latency unchanged.
- Remainder sign follows the dividend; quotient truncates toward zero.
- MULHSU: rda is signed, rdb is unsigned.
- Operands are sampled only at acceptance; changes on rda/rdb/op while busy have no effect.
- No flags are produced. Z/N/C/V remain ALU-only.

Test Plan:
- Reset then start op=MUL, rda=7, rdb=-3 -> busy high cycles 1..32, done pulse at cycle 33, result=0xFFFFFFEB; result holds afterwards.
- MULH rda=0x80000000, rdb=0x80000000 -> 0x40000000. MULHU rda=0xFFFFFFFF, rdb=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU rda=-1, rdb=2 -> 0xFFFFFFFF.
- DIV rda=-7, rdb=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU rda=0xFFFFFFFF, rdb=16 -> 0x0FFFFFFF.
- DIV and DIVU with rdb=0, rda=0x1234 -> 0xFFFFFFFF; REMU with the same operands -> 0x1234. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0. All with done at cycle 33.
- Assert start again at cycle 10 with different operands -> ignored, first result unchanged. flush at cycle 20 -> no done, busy=0 at cycle 21, result keeps the prior value. A new start at cycle 21 completes at cycle 54.
- Drive nrst low asynchronously at cycle 15 of a DIV -> busy, done and result are 0 immediately. After release, a fresh MUL 3*4 -> 12 at its 33rd cycle.
